// File: rtl/nios2_qsys_div_cell_if.sv
// Request/result bundle between the Nios II A-stage and the iterative divide cell.
interface nios2_qsys_div_cell_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              is_signed;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nios2_qsys_div_cell.sv
// Radix-2 restoring DIV/DIVU cell working on operand magnitudes with a final sign fix-up.
// Optional NIOS2_DIV_EARLY_OUT_EN: skip the iteration when the divisor is zero or exceeds the dividend.
module nios2_qsys_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios2_qsys_div_cell_if.slave dif
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] dvd_orig;
  logic              neg_q;
  logic              neg_r;
  logic              zero;
  logic [CNT_W-1:0]  cnt;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] quotient_r;
  logic [DATA_W-1:0] remainder_r;
  logic              dz_r;

  // Unsigned operands pass through untouched; MIN maps onto its own bit pattern, which is the correct magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v, input logic sgn);
    logic [DATA_W-1:0] u;
    u = v;
    return (sgn && v < 0) ? -u : u;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;
  logic              dvd_neg;
  logic              dvs_neg;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  assign dvd_mag = magnitude($signed(dif.dividend), dif.is_signed);
  assign dvs_mag = magnitude($signed(dif.divisor), dif.is_signed);
  assign dvd_neg = dif.is_signed & dif.dividend[DATA_W-1];
  assign dvs_neg = dif.is_signed & dif.divisor[DATA_W-1];

  // Partial remainder is always below the divisor, so the trial difference fits in DATA_W bits when non-negative.
  assign shifted = {rem, quo[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      dvd_orig    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero        <= 1'b0;
      cnt         <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dif.start) begin
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            dvs      <= dvs_mag;
            dvd_orig <= dif.dividend;
            zero     <= (dif.divisor == '0);
            cnt      <= '0;
            busy_r   <= 1'b1;
`ifdef NIOS2_DIV_EARLY_OUT_EN
            if (dif.divisor == '0 || dvd_mag < dvs_mag) begin
              quo   <= '0;
              rem   <= dvd_mag;
              state <= FIXUP;
            end else begin
              quo   <= dvd_mag;
              rem   <= '0;
              state <= CALC;
            end
`else
            quo   <= dvd_mag;
            rem   <= '0;
            state <= CALC;
`endif
          end
        end
        // CALC: one quotient bit per edge, MSB first
        CALC: begin
          if (!trial[DATA_W]) begin
            rem <= trial[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b1};
          end else begin
            rem <= shifted[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= FIXUP;
        end
        // FIXUP: the only edge at which the visible results change
        FIXUP: begin
          if (zero) begin
            quotient_r  <= '1;
            remainder_r <= dvd_orig;
            dz_r        <= 1'b1;
          end else begin
            quotient_r  <= apply_sign(quo, neg_q);
            remainder_r <= apply_sign(rem, neg_r);
            dz_r        <= 1'b0;
          end
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dif.busy        = busy_r;
  assign dif.done        = done_r;
  assign dif.quotient    = quotient_r;
  assign dif.remainder   = remainder_r;
  assign dif.div_by_zero = dz_r;
endmodule
